// File: rtl/alu_seq_pkg.sv
// Shared types and instruction-field layout for the ALU op sequencer.
// The instruction word is packed LSB->MSB as S, rd, ra, rb, CM, REP.
package alu_seq_pkg;

    localparam int S_W    = 4;
    localparam int CM_W   = 2;
    localparam int S_LSB  = 0;
    localparam int RD_LSB = S_W;

    typedef enum logic [1:0] {
        GRP_ARITH = 2'b00,
        GRP_LOGIC = 2'b01,
        GRP_SHR   = 2'b10,
        GRP_SHL   = 2'b11
    } grp_e;

    typedef enum logic [1:0] {
        CM_ZERO = 2'b00,
        CM_ONE  = 2'b01,
        CM_CF   = 2'b10,
        CM_RSVD = 2'b11
    } cm_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    function automatic int ra_lsb(input int ra_w);
        return RD_LSB + ra_w;
    endfunction

    function automatic int rb_lsb(input int ra_w);
        return RD_LSB + 2 * ra_w;
    endfunction

    function automatic int cm_lsb(input int ra_w);
        return RD_LSB + 3 * ra_w;
    endfunction

    function automatic int rep_lsb(input int ra_w);
        return cm_lsb(ra_w) + CM_W;
    endfunction

    function automatic int instr_width(input int ra_w, input int rep_w);
        return rep_lsb(ra_w) + rep_w;
    endfunction

    // One bit drives carry-in and both shift fills; reserved CM code behaves as zero.
    function automatic logic cm_fill(input logic [1:0] cm, input logic cf);
        logic fill;
        case (cm)
            CM_ONE:  fill = 1'b1;
            CM_CF:   fill = cf;
            default: fill = 1'b0;
        endcase
        return fill;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x 4-bit register file: one write port, two operand read ports and a debug read port.
module alu_seq_regfile #(
    parameter int NREG = 4,
    parameter int RA_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RA_W-1:0] wa,
    input  logic [3:0]      wd,
    input  logic [RA_W-1:0] ra_a,
    input  logic [RA_W-1:0] ra_b,
    input  logic [RA_W-1:0] ra_dbg,
    output logic [3:0]      rd_a,
    output logic [3:0]      rd_b,
    output logic [3:0]      rd_dbg
);

    logic [3:0] mem_q [NREG];
    logic [3:0] mem_d [NREG];

    // Next-state of every entry: the addressed one takes the write data.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = (we && (wa == RA_W'(i))) ? wd : mem_q[i];
        end
    end

    // Storage flops with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= 4'h0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_a   = mem_q[ra_a];
    assign rd_b   = mem_q[ra_b];
    assign rd_dbg = mem_q[ra_dbg];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues instructions to an external combinational 4-bit ALU, iterating REP+1 times with
// feedback into operand A, then writes the result back to the register file.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int NREG    = 4,
    parameter  int REP_W   = 2,
    localparam int RA_W    = $clog2(NREG),
    localparam int INSTR_W = instr_width(RA_W, REP_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               ld_valid,
    input  logic [RA_W-1:0]    ld_addr,
    input  logic [3:0]         ld_data,
    input  logic [RA_W-1:0]    rf_rd_addr,
    output logic [3:0]         rf_rd_data,
    output logic [3:0]         alu_A,
    output logic [3:0]         alu_B,
    output logic [3:0]         alu_S,
    output logic               alu_C_in,
    output logic               alu_A_l,
    output logic               alu_A_r,
    input  logic [3:0]         alu_O,
    input  logic               alu_C_out,
    output logic               done,
    output logic               cf,
    output logic               zf
);

    localparam int RA_LSB  = ra_lsb(RA_W);
    localparam int RB_LSB  = rb_lsb(RA_W);
    localparam int CM_LSB  = cm_lsb(RA_W);
    localparam int REP_LSB = rep_lsb(RA_W);

    state_e           state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic [1:0]       cm_q, cm_d;
    logic [3:0]       opa_q, opa_d;
    logic [3:0]       opb_q, opb_d;
    logic [REP_W-1:0] iter_q, iter_d;
    logic             cf_q, cf_d;
    logic             zf_q, zf_d;
    logic             done_q, done_d;

    logic             rf_we_s;
    logic [RA_W-1:0]  rf_wa_s;
    logic [3:0]       rf_wd_s;
    logic [3:0]       rf_a_s;
    logic [3:0]       rf_b_s;
    logic             fill_s;

    alu_seq_regfile #(
        .NREG (NREG),
        .RA_W (RA_W)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we_s),
        .wa     (rf_wa_s),
        .wd     (rf_wd_s),
        .ra_a   (instr[RA_LSB +: RA_W]),
        .ra_b   (instr[RB_LSB +: RA_W]),
        .ra_dbg (rf_rd_addr),
        .rd_a   (rf_a_s),
        .rd_b   (rf_b_s),
        .rd_dbg (rf_rd_data)
    );

    // Next-state, operand/flag updates and register-file write selection.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        rd_d    = rd_q;
        cm_d    = cm_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        iter_d  = iter_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        done_d  = 1'b0;
        rf_we_s = 1'b0;
        rf_wa_s = ld_addr;
        rf_wd_s = ld_data;
        case (state_q)
            ST_IDLE: begin
                // Operands come from the pre-write RF even when a load lands this cycle.
                rf_we_s = ld_valid;
                if (instr_valid) begin
                    s_d     = instr[S_LSB +: S_W];
                    rd_d    = instr[RD_LSB +: RA_W];
                    cm_d    = instr[CM_LSB +: CM_W];
                    opa_d   = rf_a_s;
                    opb_d   = rf_b_s;
                    iter_d  = instr[REP_LSB +: REP_W];
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                opa_d = alu_O;
                case (s_q[3:2])
                    GRP_ARITH: cf_d = alu_C_out;
                    GRP_SHR:   cf_d = opa_q[0];
                    GRP_SHL:   cf_d = opa_q[3];
                    default:   cf_d = cf_q;
                endcase
                if (iter_q == '0) begin
                    state_d = ST_WB;
                end else begin
                    iter_d = iter_q - REP_W'(1);
                end
            end
            ST_WB: begin
                rf_we_s = 1'b1;
                rf_wa_s = rd_q;
                rf_wd_s = opa_q;
                zf_d    = (opa_q == 4'h0);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= 4'h0;
            rd_q    <= '0;
            cm_q    <= 2'b00;
            opa_q   <= 4'h0;
            opb_q   <= 4'h0;
            iter_q  <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            rd_q    <= rd_d;
            cm_q    <= cm_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            iter_q  <= iter_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            done_q  <= done_d;
        end
    end

    // Fill follows the live cf so each iteration sees the carry left by the previous one.
    assign fill_s      = cm_fill(cm_q, cf_q);
    assign instr_ready = (state_q == ST_IDLE);
    assign alu_A       = opa_q;
    assign alu_B       = opb_q;
    assign alu_S       = s_q;
    assign alu_C_in    = fill_s;
    assign alu_A_l     = fill_s;
    assign alu_A_r     = fill_s;
    assign done        = done_q;
    assign cf          = cf_q;
    assign zf          = zf_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the external ALU, keeps an instruction-level reference
// model, compares every cycle, and runs directed scenarios plus a randomized phase.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [15:0] aseq;
        logic [3:0]  fseq;
        logic [3:0]  res;
        logic        cf;
    } op_res_t;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [13:0] instr;
    logic        ld_valid;
    logic [1:0]  ld_addr;
    logic [3:0]  ld_data;
    logic [1:0]  rf_rd_addr;
    logic [3:0]  rf_rd_data;
    logic [3:0]  alu_A, alu_B, alu_S, alu_O;
    logic        alu_C_in, alu_A_l, alu_A_r, alu_C_out;
    logic        done, cf, zf;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] a_trace [8];

    alu_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .alu_A       (alu_A),
        .alu_B       (alu_B),
        .alu_S       (alu_S),
        .alu_C_in    (alu_C_in),
        .alu_A_l     (alu_A_l),
        .alu_A_r     (alu_A_r),
        .alu_O       (alu_O),
        .alu_C_out   (alu_C_out),
        .done        (done),
        .cf          (cf),
        .zf          (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The 4-bit ALU as described: returns {carry, result}.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s, input logic fill);
        logic [4:0] r;
        case (s[3:2])
            2'b00: begin
                case (s[1:0])
                    2'b00:   r = {1'b0, a} + {1'b0, b}  + {4'b0000, fill};
                    2'b01:   r = {1'b0, a} + {1'b0, ~b} + {4'b0000, fill};
                    2'b10:   r = {1'b0, a} + {4'b0000, fill};
                    default: r = {1'b0, a} + 5'b01111 + {4'b0000, fill};
                endcase
            end
            2'b01: begin
                case (s[1:0])
                    2'b00:   r = {1'b0, a & b};
                    2'b01:   r = {1'b0, a | b};
                    2'b10:   r = {1'b0, a ^ b};
                    default: r = {1'b0, ~a};
                endcase
            end
            2'b10:   r = {1'b0, fill, a[3:1]};
            default: r = {1'b0, a[2:0], fill};
        endcase
        return r;
    endfunction

    logic       alu_fill;
    logic [4:0] alu_res;
    always_comb begin
        case (alu_S[3:2])
            2'b10:   alu_fill = alu_A_l;
            2'b11:   alu_fill = alu_A_r;
            default: alu_fill = alu_C_in;
        endcase
    end
    assign alu_res   = alu_f(alu_A, alu_B, alu_S, alu_fill);
    assign alu_O     = alu_res[3:0];
    assign alu_C_out = alu_res[4];

    // Whole-instruction reference: play REP+1 iterations with carry feedback.
    function automatic op_res_t run_model(input logic [3:0] a0, input logic [3:0] b,
                                          input logic [3:0] s, input logic [1:0] cm,
                                          input logic [1:0] rep, input logic cf0);
        op_res_t    r;
        logic [3:0] a;
        logic       c;
        logic       fill;
        logic [4:0] co;
        r = '0;
        a = a0;
        c = cf0;
        for (int k = 0; k <= int'(rep); k++) begin
            fill = (cm == 2'b01) ? 1'b1 : ((cm == 2'b10) ? c : 1'b0);
            r.aseq[k*4 +: 4] = a;
            r.fseq[k] = fill;
            co = alu_f(a, b, s, fill);
            if (s[3:2] == 2'b00) c = co[4];
            else if (s[3:2] == 2'b10) c = a[0];
            else if (s[3:2] == 2'b11) c = a[3];
            a = co[3:0];
        end
        r.res = a;
        r.cf  = c;
        return r;
    endfunction

    logic [3:0] m_rf [4];
    logic       m_cf, m_zf, m_done, m_busy;
    int         m_left, m_phase, m_rep;
    logic [1:0] m_rd;
    logic [3:0] m_s, m_b;
    op_res_t    m_op;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_cf    <= 1'b0;
            m_zf    <= 1'b0;
            m_left  <= 0;
            m_phase <= 0;
            m_rep   <= 0;
            for (int i = 0; i < 4; i++) m_rf[i] <= 4'h0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_phase <= m_phase + 1;
                m_left  <= m_left - 1;
                if (m_left == 1) begin
                    m_busy     <= 1'b0;
                    m_rf[m_rd] <= m_op.res;
                    m_zf       <= (m_op.res == 4'h0);
                    m_cf       <= m_op.cf;
                    m_done     <= 1'b1;
                end
            end else begin
                if (instr_valid) begin
                    m_op    <= run_model(m_rf[instr[7:6]], m_rf[instr[9:8]], instr[3:0],
                                         instr[11:10], instr[13:12], m_cf);
                    m_s     <= instr[3:0];
                    m_b     <= m_rf[instr[9:8]];
                    m_rd    <= instr[5:4];
                    m_rep   <= int'(instr[13:12]);
                    m_left  <= int'(instr[13:12]) + 2;
                    m_phase <= 0;
                    m_busy  <= 1'b1;
                end
                if (ld_valid) m_rf[ld_addr] <= ld_data;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference model.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            check("ready", instr_ready, !m_busy);
            check("done", done, m_done);
            check("rf_dbg", rf_rd_data, m_rf[rf_rd_addr]);
            if (!m_busy) begin
                check("cf", cf, m_cf);
                check("zf", zf, m_zf);
            end else if (m_phase <= m_rep) begin
                check("alu_A", alu_A, m_op.aseq[m_phase*4 +: 4]);
                check("alu_B", alu_B, m_b);
                check("alu_S", alu_S, m_s);
                check("alu_fill", {alu_C_in, alu_A_l, alu_A_r}, {3{m_op.fseq[m_phase]}});
            end
        end
    end

    function automatic logic [13:0] mk(input logic [3:0] s, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic [1:0] cm, input logic [1:0] rep);
        return {rep, cm, rb, ra, rd, s};
    endfunction

    task automatic peek(input logic [1:0] a, input logic [3:0] exp, input string name);
        rf_rd_addr = a;
        #1;
        check(name, rf_rd_data, exp);
    endtask

    task automatic do_ld(input logic [1:0] a, input logic [3:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (instr_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("wait_idle", instr_ready, 1'b1);
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (lat < 8) a_trace[lat] = alu_A;
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic run_op(input logic [3:0] s, input logic [1:0] rd, input logic [1:0] ra,
                          input logic [1:0] rb, input logic [1:0] cm, input logic [1:0] rep,
                          input string name);
        wait_idle();
        instr       = mk(s, rd, ra, rb, cm, rep);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        wait_done(2 + int'(rep), name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 14'h0;
        ld_valid = 1'b0;
        ld_addr = 2'd0;
        ld_data = 4'h0;
        rf_rd_addr = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_alu", {alu_A, alu_B, alu_S, alu_C_in, alu_A_l, alu_A_r}, 32'h0);
        check("rst_flags", {done, cf, zf}, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", instr_ready, 1'b1);

        // 1: 0101 + 0011 = 1000
        do_ld(2'd1, 4'b0101);
        do_ld(2'd2, 4'b0011);
        run_op(4'b0000, 2'd0, 2'd1, 2'd2, 2'b00, 2'd0, "t1");
        peek(2'd0, 4'b1000, "t1_r0");
        check("t1_flags", {cf, zf}, 2'b00);

        // 2: subtract-style A+~B+1
        do_ld(2'd1, 4'b0011);
        do_ld(2'd2, 4'b0101);
        run_op(4'b0001, 2'd0, 2'd1, 2'd2, 2'b01, 2'd0, "t2a");
        peek(2'd0, 4'b1110, "t2a_r0");
        check("t2a_cf", cf, 1'b0);
        do_ld(2'd1, 4'b0101);
        run_op(4'b0001, 2'd0, 2'd1, 2'd2, 2'b01, 2'd0, "t2b");
        peek(2'd0, 4'b0000, "t2b_r0");
        check("t2b_flags", {cf, zf}, 2'b11);

        // 4: logic op leaves cf alone; CM=10 feeds cf as carry-in
        do_ld(2'd1, 4'b1010);
        do_ld(2'd2, 4'b0110);
        run_op(4'b0110, 2'd0, 2'd1, 2'd2, 2'b00, 2'd0, "t4a");
        peek(2'd0, 4'b1100, "t4a_r0");
        check("t4a_cf", cf, 1'b1);
        do_ld(2'd1, 4'b0001);
        do_ld(2'd2, 4'b0001);
        run_op(4'b0000, 2'd0, 2'd1, 2'd2, 2'b10, 2'd0, "t4b");
        peek(2'd0, 4'b0011, "t4b_r0");

        // 3: shift right with ones fill, four iterations
        do_ld(2'd1, 4'b1000);
        run_op(4'b1000, 2'd0, 2'd1, 2'd0, 2'b01, 2'd3, "t3");
        check("t3_trace", {a_trace[0], a_trace[1], a_trace[2], a_trace[3]}, 16'h8CEF);
        peek(2'd0, 4'b1111, "t3_r0");
        check("t3_cf", cf, 1'b1);

        // load and accept in the same cycle: operand is the pre-write value
        do_ld(2'd1, 4'h2);
        wait_idle();
        instr = mk(4'b0010, 2'd0, 2'd1, 2'd2, 2'b00, 2'd0);
        instr_valid = 1'b1;
        ld_valid = 1'b1;
        ld_addr = 2'd1;
        ld_data = 4'h7;
        @(negedge clk);
        instr_valid = 1'b0;
        ld_valid = 1'b0;
        wait_done(2, "same_cycle");
        peek(2'd0, 4'h2, "same_cycle_r0");
        peek(2'd1, 4'h7, "same_cycle_r1");

        // rd == ra with repeats: shift left 0001 three times
        do_ld(2'd1, 4'b0001);
        run_op(4'b1100, 2'd1, 2'd1, 2'd0, 2'b00, 2'd2, "rd_eq_ra");
        peek(2'd1, 4'b1000, "rd_eq_ra_r1");

        // 5: held valid, mid-op load ignored, back-to-back accept
        do_ld(2'd1, 4'b0011);
        do_ld(2'd3, 4'h4);
        wait_idle();
        instr = mk(4'b1100, 2'd0, 2'd1, 2'd0, 2'b00, 2'd3);
        instr_valid = 1'b1;
        @(negedge clk);
        instr = mk(4'b0100, 2'd2, 2'd1, 2'd1, 2'b00, 2'd0);
        ld_valid = 1'b1;
        ld_addr = 2'd3;
        ld_data = 4'hA;
        begin
            int lat = 0;
            while (done !== 1'b1 && lat < 40) begin
                check("t5_busy_ready", instr_ready, 1'b0);
                @(negedge clk);
                ld_valid = 1'b0;
                lat++;
            end
            check("t5_latency", lat, 5);
        end
        check("t5_ready_idle", instr_ready, 1'b1);
        @(negedge clk);
        check("t5_second_accepted", instr_ready, 1'b0);
        instr_valid = 1'b0;
        wait_done(2, "t5b");
        peek(2'd0, 4'h0, "t5_r0");
        peek(2'd2, 4'b0011, "t5_r2");
        peek(2'd3, 4'h4, "t5_r3_unchanged");

        // 6: reset in the second EXEC cycle aborts the op
        do_ld(2'd1, 4'h5);
        do_ld(2'd2, 4'h5);
        run_op(4'b0001, 2'd3, 2'd1, 2'd2, 2'b01, 2'd0, "t6_pre");
        check("t6_pre_flags", {cf, zf}, 2'b11);
        wait_idle();
        instr = mk(4'b1000, 2'd3, 2'd1, 2'd2, 2'b01, 2'd3);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_state", {done, cf, zf, alu_A}, 7'h00);
        for (int r = 0; r < 4; r++) peek(2'(r), 4'h0, "t6_rf_clear");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready_after", instr_ready, 1'b1);
        check("t6_no_done", done, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            instr_valid = ($urandom_range(0, 2) == 0);
            instr       = 14'($urandom);
            ld_valid    = ($urandom_range(0, 3) == 0);
            ld_addr     = 2'($urandom);
            ld_data     = 4'($urandom);
            rf_rd_addr  = 2'($urandom);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        ld_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
